// File: rtl/axi_lite_pkg.sv
// Shared types, response codes and register offsets for the AXI-Lite register bank.
package axi_lite_pkg;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 8;
    localparam int WIDX_W = ADDR_W - 2;

    typedef logic [DATA_W-1:0] data_t;
    typedef logic [ADDR_W-1:0] addr_t;
    typedef logic [1:0]        resp_t;
    typedef logic [WIDX_W-1:0] widx_t;

    localparam resp_t RESP_OKAY   = 2'b00;
    localparam resp_t RESP_SLVERR = 2'b10;

    localparam addr_t OFF_ID     = 8'h00;
    localparam addr_t OFF_STATUS = 8'h04;
    localparam addr_t OFF_IRQ    = 8'h08;
    localparam addr_t OFF_CTRL0  = 8'h0C;

    typedef enum logic       {W_IDLE, W_ACK}          wr_state_e;
    typedef enum logic [1:0] {R_IDLE, R_WAIT, R_DONE} rd_state_e;

    function automatic widx_t word_idx(input addr_t a);
        return a[ADDR_W-1:2];
    endfunction

endpackage

// File: rtl/axi_lite_reg_decode.sv
// Combinational byte-address decode for one access direction (read or write).
module axi_lite_reg_decode
    import axi_lite_pkg::*;
#(
    parameter int NUM_CTRL = 4,
    parameter bit IS_WRITE = 1'b0
) (
    input  addr_t addr,
    output logic  hit_id,
    output logic  hit_status,
    output logic  hit_irq,
    output logic  hit_ctrl,
    output widx_t ctrl_idx,
    output logic  err
);

    widx_t widx;
    logic  aligned;

    always_comb begin
        widx       = word_idx(addr);
        aligned    = (addr[1:0] == 2'b00);
        hit_id     = aligned && (widx == word_idx(OFF_ID));
        hit_status = aligned && (widx == word_idx(OFF_STATUS));
        hit_irq    = aligned && (widx == word_idx(OFF_IRQ));
        ctrl_idx   = widx - word_idx(OFF_CTRL0);
        hit_ctrl   = aligned && (widx >= word_idx(OFF_CTRL0)) && (int'(ctrl_idx) < NUM_CTRL);
        // ID and STATUS are read-only, so a write to them is a decode error
        err        = !(hit_id || hit_status || hit_irq || hit_ctrl)
                   || (IS_WRITE && (hit_id || hit_status));
    end

endmodule

// File: rtl/axi_lite_regfile.sv
// Register bank: ID/STATUS read-only, W1C IRQ word, NUM_CTRL RW control words,
// independent write and read FSMs with a configurable read latency.
module axi_lite_regfile
    import axi_lite_pkg::*;
#(
    parameter int    NUM_CTRL     = 4,
    parameter int    READ_LATENCY = 1,
    parameter data_t ID_VALUE     = 32'hA110_0001,
    parameter data_t CTRL_RESET   = 32'h0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  data_t                      wdata,
    input  addr_t                      waddr,
    input  logic                       wvalid,
    output logic                       wready,
    output resp_t                      bresp,
    input  addr_t                      raddr,
    input  logic                       rready,
    output data_t                      rdata,
    output logic                       rvalid,
    output resp_t                      rresp,
    input  data_t                      hw_status,
    input  data_t                      hw_event,
    output logic [NUM_CTRL*DATA_W-1:0] ctrl_o,
    output logic [NUM_CTRL-1:0]        ctrl_wr,
    output logic                       irq_o
);

    localparam logic [2:0] CNT_INIT = 3'(READ_LATENCY - 1);

    wr_state_e w_state_q;
    rd_state_e r_state_q;
    logic [2:0] cnt_q;
    addr_t raddr_q;
    logic  wready_q, rvalid_q;
    resp_t bresp_q, rresp_q;
    data_t rdata_q;
    logic [NUM_CTRL-1:0] ctrl_wr_q, wr_sel;
    logic [NUM_CTRL-1:0][DATA_W-1:0] ctrl_q, ctrl_d;
    data_t irq_q, irq_d;

    logic  w_hit_id, w_hit_status, w_hit_irq, w_hit_ctrl, w_err;
    logic  r_hit_id, r_hit_status, r_hit_irq, r_hit_ctrl, r_err;
    widx_t w_idx, r_idx;
    logic  wr_fire, wr_ok;
    data_t rd_word;

    axi_lite_reg_decode #(.NUM_CTRL(NUM_CTRL), .IS_WRITE(1'b1)) u_wdec (
        .addr(waddr), .hit_id(w_hit_id), .hit_status(w_hit_status), .hit_irq(w_hit_irq),
        .hit_ctrl(w_hit_ctrl), .ctrl_idx(w_idx), .err(w_err)
    );

    axi_lite_reg_decode #(.NUM_CTRL(NUM_CTRL), .IS_WRITE(1'b0)) u_rdec (
        .addr(raddr_q), .hit_id(r_hit_id), .hit_status(r_hit_status), .hit_irq(r_hit_irq),
        .hit_ctrl(r_hit_ctrl), .ctrl_idx(r_idx), .err(r_err)
    );

    // wready still high means the master has not yet dropped the accepted request
    always_comb begin
        wr_fire = (w_state_q == W_IDLE) && wvalid && !wready_q;
        wr_ok   = wr_fire && !w_err;
        wr_sel  = '0;
        ctrl_d  = ctrl_q;
        for (int k = 0; k < NUM_CTRL; k++) begin
            if (wr_ok && w_hit_ctrl && (w_idx == WIDX_W'(k))) begin
                wr_sel[k] = 1'b1;
                ctrl_d[k] = wdata;
            end
        end
        irq_d = (irq_q & ~((wr_ok && w_hit_irq) ? wdata : '0)) | hw_event;
    end

    always_comb begin
        rd_word = '0;
        if (r_hit_id)          rd_word = ID_VALUE;
        else if (r_hit_status) rd_word = hw_status;
        else if (r_hit_irq)    rd_word = irq_q;
        else begin
            for (int k = 0; k < NUM_CTRL; k++)
                if (r_hit_ctrl && (r_idx == WIDX_W'(k))) rd_word = ctrl_q[k];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ctrl_q <= {NUM_CTRL{CTRL_RESET}};
            irq_q  <= '0;
        end else begin
            ctrl_q <= ctrl_d;
            irq_q  <= irq_d;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            w_state_q <= W_IDLE;
            wready_q  <= 1'b0;
            bresp_q   <= RESP_OKAY;
            ctrl_wr_q <= '0;
        end else begin
            wready_q  <= 1'b0;
            ctrl_wr_q <= '0;
            case (w_state_q)
                W_IDLE: if (wr_fire) begin
                    bresp_q   <= w_err ? RESP_SLVERR : RESP_OKAY;
                    ctrl_wr_q <= wr_sel;
                    w_state_q <= W_ACK;
                end
                W_ACK: begin
                    wready_q  <= 1'b1;
                    w_state_q <= W_IDLE;
                end
                default: w_state_q <= W_IDLE;
            endcase
        end
    end

    // Capture happens on the edge leaving R_DONE so rvalid lands READ_LATENCY edges after the sample
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state_q <= R_IDLE;
            cnt_q     <= '0;
            raddr_q   <= '0;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
            rresp_q   <= RESP_OKAY;
        end else begin
            rvalid_q <= 1'b0;
            case (r_state_q)
                R_IDLE: if (rready && !rvalid_q) begin
                    raddr_q   <= raddr;
                    cnt_q     <= CNT_INIT;
                    r_state_q <= (READ_LATENCY == 1) ? R_DONE : R_WAIT;
                end
                R_WAIT: begin
                    cnt_q <= cnt_q - 3'd1;
                    if (cnt_q == 3'd1) r_state_q <= R_DONE;
                end
                R_DONE: begin
                    rdata_q   <= r_err ? '0 : rd_word;
                    rresp_q   <= r_err ? RESP_SLVERR : RESP_OKAY;
                    rvalid_q  <= 1'b1;
                    r_state_q <= R_IDLE;
                end
                default: r_state_q <= R_IDLE;
            endcase
        end
    end

    assign wready  = wready_q;
    assign bresp   = bresp_q;
    assign rvalid  = rvalid_q;
    assign rdata   = rdata_q;
    assign rresp   = rresp_q;
    assign ctrl_wr = ctrl_wr_q;
    assign ctrl_o  = ctrl_q;
    assign irq_o   = |irq_q;

endmodule

// File: tb/tb_axi_lite_regfile.sv
// Directed bench for axi_lite_regfile: one READ_LATENCY=1 instance and one READ_LATENCY=4 instance.
module tb_axi_lite_regfile;
    import axi_lite_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    data_t wdata, rdata, hw_status, hw_event;
    addr_t waddr, raddr;
    logic wvalid, wready, rready, rvalid, irq_o;
    resp_t bresp, rresp;
    logic [127:0] ctrl_o;
    logic [3:0] ctrl_wr;

    data_t wdata4, rdata4;
    addr_t waddr4, raddr4;
    logic wvalid4, wready4, rready4, rvalid4, irq_o4;
    resp_t bresp4, rresp4;
    logic [127:0] ctrl_o4;
    logic [3:0] ctrl_wr4;

    int n_cmp = 0;
    int n_bad = 0;

    axi_lite_regfile #(.NUM_CTRL(4), .READ_LATENCY(1)) dut (
        .clk(clk), .rst(rst), .wdata(wdata), .waddr(waddr), .wvalid(wvalid), .wready(wready),
        .bresp(bresp), .raddr(raddr), .rready(rready), .rdata(rdata), .rvalid(rvalid),
        .rresp(rresp), .hw_status(hw_status), .hw_event(hw_event), .ctrl_o(ctrl_o),
        .ctrl_wr(ctrl_wr), .irq_o(irq_o)
    );

    axi_lite_regfile #(.NUM_CTRL(4), .READ_LATENCY(4)) dut4 (
        .clk(clk), .rst(rst), .wdata(wdata4), .waddr(waddr4), .wvalid(wvalid4), .wready(wready4),
        .bresp(bresp4), .raddr(raddr4), .rready(rready4), .rdata(rdata4), .rvalid(rvalid4),
        .rresp(rresp4), .hw_status(hw_status), .hw_event(hw_event), .ctrl_o(ctrl_o4),
        .ctrl_wr(ctrl_wr4), .irq_o(irq_o4)
    );

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic do_write(input addr_t a, input data_t d, input data_t ev,
                            output logic [3:0] pulse, output resp_t r);
        int lat;
        waddr = a; wdata = d; wvalid = 1'b1; hw_event = ev;
        @(posedge clk); #1;
        pulse = ctrl_wr; hw_event = '0;
        lat = 0;
        while (!wready && lat < 8) begin @(posedge clk); #1; lat++; end
        chk("wready_lat", lat, 1);
        r = bresp; wvalid = 1'b0;
        @(posedge clk); #1;
        chk("wready_1cyc", wready, 0);
    endtask

    task automatic do_read(input addr_t a, output data_t d, output resp_t r);
        int lat;
        raddr = a; rready = 1'b1;
        @(posedge clk); #1;
        lat = 0;
        while (!rvalid && lat < 20) begin @(posedge clk); #1; lat++; end
        chk("rvalid_lat", lat, 1);
        d = rdata; r = rresp; rready = 1'b0;
        @(posedge clk); #1;
        chk("rvalid_1cyc", rvalid, 0);
    endtask

    logic [3:0] pls;
    resp_t rs;
    data_t rd;
    logic saw;
    int lat4;

    initial begin
        wdata = '0; waddr = '0; wvalid = 0; raddr = '0; rready = 0;
        wdata4 = '0; waddr4 = '0; wvalid4 = 0; raddr4 = '0; rready4 = 0;
        hw_status = '0; hw_event = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        chk("rst_wready", wready, 0);
        chk("rst_rvalid", rvalid, 0);
        chk("rst_rdata", rdata, 0);
        chk("rst_ctrl_o", ctrl_o, 0);
        chk("rst_irq", irq_o, 0);
        chk("rst_bresp", bresp, RESP_OKAY);

        do_read(8'h00, rd, rs);
        chk("id_data", rd, 32'hA110_0001);
        chk("id_resp", rs, RESP_OKAY);

        do_write(8'h0C, 32'hDEAD_BEEF, '0, pls, rs);
        chk("w0_pulse", pls, 4'b0001);
        chk("w0_bresp", rs, RESP_OKAY);
        chk("w0_ctrl", ctrl_o[31:0], 32'hDEAD_BEEF);
        chk("w0_pulse_gone", ctrl_wr, 0);
        do_read(8'h0C, rd, rs);
        chk("r0_data", rd, 32'hDEAD_BEEF);

        do_write(8'h04, 32'h1111_1111, '0, pls, rs);
        chk("w_ro_bresp", rs, RESP_SLVERR);
        chk("w_ro_pulse", pls, 0);
        do_write(8'h00, 32'h2222_2222, '0, pls, rs);
        chk("w_id_bresp", rs, RESP_SLVERR);
        do_write(8'h0E, 32'h3333_3333, '0, pls, rs);
        chk("w_unal_bresp", rs, RESP_SLVERR);
        chk("w_unal_pulse", pls, 0);
        chk("w_err_ctrl", ctrl_o, {96'h0, 32'hDEAD_BEEF});
        do_read(8'h1C, rd, rs);
        chk("r_oob_resp", rs, RESP_SLVERR);
        chk("r_oob_data", rd, 0);
        do_read(8'h18, rd, rs);
        chk("r_last_resp", rs, RESP_OKAY);
        chk("r_last_data", rd, 0);
        do_write(8'h18, 32'h0BAD_F00D, '0, pls, rs);
        chk("w_last_pulse", pls, 4'b1000);
        chk("w_last_ctrl", ctrl_o[127:96], 32'h0BAD_F00D);

        hw_status = 32'h1357_9BDF;
        do_read(8'h04, rd, rs);
        chk("status", rd, 32'h1357_9BDF);

        hw_event = 32'h5;
        @(posedge clk); #1;
        hw_event = '0;
        chk("irq_set", irq_o, 1);
        do_read(8'h08, rd, rs);
        chk("irq_rd5", rd, 32'h5);
        do_read(8'h08, rd, rs);
        chk("irq_no_rc", rd, 32'h5);
        do_write(8'h08, 32'h1, '0, pls, rs);
        do_read(8'h08, rd, rs);
        chk("irq_w1c", rd, 32'h4);
        do_write(8'h08, 32'h4, 32'h4, pls, rs);
        do_read(8'h08, rd, rs);
        chk("irq_set_dom", rd, 32'h4);
        do_write(8'h08, 32'h4, '0, pls, rs);
        chk("irq_clr", irq_o, 0);

        // read capture and write commit on the same edge: read sees the old value
        raddr = 8'h10; rready = 1'b1;
        @(posedge clk); #1;
        waddr = 8'h10; wdata = 32'h77; wvalid = 1'b1;
        @(posedge clk); #1;
        chk("ovl_rvalid", rvalid, 1);
        chk("ovl_old", rdata, 0);
        chk("ovl_ctrl1", ctrl_o[63:32], 32'h77);
        rready = 1'b0;
        @(posedge clk); #1;
        wvalid = 1'b0;
        @(posedge clk); #1;
        do_read(8'h10, rd, rs);
        chk("ovl_new", rd, 32'h77);

        // READ_LATENCY=4 with a write landing mid-wait
        raddr4 = 8'h0C; rready4 = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("l4_early", rvalid4, 0);
        waddr4 = 8'h0C; wdata4 = 32'h1234; wvalid4 = 1'b1;
        @(posedge clk); #1;
        chk("l4_wpulse", ctrl_wr4, 4'b0001);
        @(posedge clk); #1;
        chk("l4_wready", wready4, 1);
        chk("l4_not_yet", rvalid4, 0);
        wvalid4 = 1'b0;
        @(posedge clk); #1;
        chk("l4_rvalid", rvalid4, 1);
        chk("l4_rdata", rdata4, 32'h1234);
        rready4 = 1'b0;
        @(posedge clk); #1;

        // reset while read waits and write acknowledges
        raddr4 = 8'h0C; rready4 = 1'b1; waddr4 = 8'h10; wdata4 = 32'hCAFE; wvalid4 = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; rready4 = 1'b0; wvalid4 = 1'b0;
        #1;
        chk("ar_wready", wready4, 0);
        chk("ar_rvalid", rvalid4, 0);
        chk("ar_ctrl_wr", ctrl_wr4, 0);
        chk("ar_rdata", rdata4, 0);
        chk("ar_ctrl_o", ctrl_o4, 0);
        chk("ar_irq", irq_o4, 0);
        chk("ar_rresp", rresp4, RESP_OKAY);
        saw = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (i == 1) rst = 1'b1;
            saw = saw | rvalid4 | wready4;
        end
        chk("ar_no_pulse", saw, 0);
        raddr4 = 8'h00; rready4 = 1'b1;
        @(posedge clk); #1;
        lat4 = 0;
        while (!rvalid4 && lat4 < 20) begin @(posedge clk); #1; lat4++; end
        rready4 = 1'b0;
        chk("ar_rd_lat", lat4, 4);
        chk("ar_rd_data", rdata4, 32'hA110_0001);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/axi_lite_regfile.md
Name: axi_lite_regfile

Overview:
- Register bank behind the AXI-Lite slave adapter; consumes the adapter's external write/read request interface and returns data and response codes.
- Holds one read-only ID word, one read-only status word, one W1C interrupt word and NUM_CTRL read/write control words.
- Drives control words and per-register write strobes to downstream hardware.
- Provides a configurable read latency to model a slow register path.

Parameters:
- NUM_CTRL, 4, number of RW control registers (1..60).
- READ_LATENCY, 1, cycles from read request accept to rvalid (1..8).
- ID_VALUE, 32'hA110_0001, constant returned at offset 0x00.
- CTRL_RESET, 32'h0, reset value of every control register.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous reset, active-low.
- wdata  in  data_t  write data.
- waddr  in  addr_t  write byte address.
- wvalid  in  1  write request, held until accepted.
- wready  out  1  one-cycle write-accept pulse.
- bresp  out  resp_t  write response, held until the next write.
- raddr  in  addr_t  read byte address.
- rready  in  1  read request, held until rvalid.
- rdata  out  data_t  read data, held until the next read.
- rvalid  out  1  one-cycle read-data pulse.
- rresp  out  resp_t  read response, held with rdata.
- hw_status  in  data_t  live status word.
- hw_event  in  data_t  per-bit interrupt set pulses.
- ctrl_o  out  NUM_CTRL*DATA_W  flat control words; word k is at bits [k*DATA_W +: DATA_W].
- ctrl_wr  out  NUM_CTRL  one-cycle pulse per control word on a successful write.
- irq_o  out  1  OR-reduction of the IRQ register.

Behaviour:
- Reset (rst=0, asynchronous) drives these values:
  - wready=0, rvalid=0, ctrl_wr=0.
  - bresp=OKAY, rresp=OKAY, rdata=0.
  - IRQ register=0, so irq_o=0.
  - All control words=CTRL_RESET.
  - Both FSMs go to IDLE.
- Address map (byte offsets, word index = addr[ADDR_W-1:2]):
  - 0x00 ID: RO.
  - 0x04 STATUS: RO, returns hw_status sampled at the read-capture edge.
  - 0x08 IRQ: W1C.
  - 0x0C + 4k CTRL[k]: RW, k < NUM_CTRL.
- Decode errors return SLVERR:
  - addr[1:0] != 0 (unaligned).
  - Index beyond the last CTRL word.
  - Write to ID or STATUS.
  - On SLVERR no state changes; read data returns 0.
- Write FSM, states W_IDLE and W_ACK:
  - W_IDLE with wvalid=1 → at that edge: commit the write, register bresp, pulse the matching ctrl_wr bit for one cycle, go to W_ACK.
  - W_ACK: wready=1 for exactly one cycle, then W_IDLE unconditionally.
  - A new write is therefore sampled no earlier than 2 cycles after the previous one.
  - bresp is valid from the wready cycle and held until the next commit.
- IRQ register, per bit:
  - next = (irq & ~(w1c_mask)) | hw_event.
  - Set dominates clear when both occur in the same cycle.
  - Reads never clear it.
- Read FSM, states R_IDLE, R_WAIT, R_DONE:
  - R_IDLE with rready=1 → sample raddr, load counter=READ_LATENCY-1, go to R_WAIT (or R_DONE if READ_LATENCY=1).
  - R_WAIT: decrement the counter; at 0 go to R_DONE.
  - Entry to R_DONE: capture rdata and rresp from the current register contents, including writes committed before that edge.
  - R_DONE: rvalid=1 for exactly one cycle, then R_IDLE.
  - Latency: rvalid is high READ_LATENCY cycles after the request-sample edge.
  - rdata and rresp hold until the next capture.
- Read and write paths are independent and may overlap.
  - If a write commit and a read capture fall on the same edge, the read returns the pre-write value.
- Reset asserted mid-transaction aborts both FSMs to IDLE; no pulse completes.

Decomposition:
- Types and constants in axi_lite_pkg: data_t, addr_t, resp_t, RESP_OKAY=2'b00, RESP_SLVERR=2'b10, plus offset constants OFF_ID, OFF_STATUS, OFF_IRQ, OFF_CTRL0.
- One sub-module, axi_lite_reg_decode: combinational address → {hit_id, hit_status, hit_irq, ctrl_idx, err} for a given direction.
- Instantiate it twice, once for the write path and once for the read path.

Test Plan:
- Reset release → wready=0, rvalid=0, rdata=0, ctrl_o all CTRL_RESET, irq_o=0; read 0x00 → rdata=32'hA110_0001, rresp=OKAY, rvalid high exactly 1 cycle after request (READ_LATENCY=1).
- Write 0x0C=32'hDEAD_BEEF → ctrl_wr[0] pulses 1 cycle, wready pulses the following cycle, bresp=OKAY, ctrl_o word0=DEAD_BEEF; read back 0x0C → DEAD_BEEF.
- Write 0x04 (RO), write 0x0E (unaligned), read 0x0C+4*NUM_CTRL → bresp/rresp=SLVERR, ctrl_o unchanged, rdata=0.
- hw_event=32'h5 for one cycle → irq_o=1; read 0x08 → 5; write 0x08=32'h1 → reads 4; write 0x08=32'h4 in the same cycle as hw_event=32'h4 → bit 2 stays set.
- READ_LATENCY=4: read 0x0C issued, write 0x0C=32'h1234 committed 2 cycles later → rvalid at cycle 4 with rdata=32'h1234.
- Assert rst while the read FSM is in R_WAIT and write FSM in W_ACK → rvalid and wready never pulse, all outputs return to reset values, next read completes normally.
